parking_gate_ctrl: RTL and testbench

//  Parametrised successor to the single-gate parking_system.
//  - Controls one entry barrier via a password check.
//  - Adds occupancy tracking against CAPACITY and a per-visit timeout.
//  - Adds lockout after MAX_TRIES consecutive wrong passwords.
//  - Sits between the entrance/exit sensors plus keypad and the gate LEDs; exposes state for coverage.
//

---
 rtl/parking_gate_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl
//
// Controller for a single parking-lot entry barrier. A car at the entrance
// starts a password exchange on the keypad. A correct password opens the
// barrier. Repeated wrong passwords lock the keypad out for a while.
// The block also tracks how many cars are inside, against a fixed capacity,
// and abandons a visit that stalls at the keypad.
//
// Ports
//   clk             in   1      system clock, rising edge
//   reset_n         in   1      asynchronous active-low reset
//   sensor_entrance in   1      car present at the entry barrier (level)
//   sensor_exit     in   1      car has cleared the barrier (level)
//   password_1      in   PW_W   keypad field 1
//   password_2      in   PW_W   keypad field 2
//   pass_valid      in   1      strobe: password fields valid this cycle
//   car_departed    in   1      strobe: a car left the lot
//   GREEN_LED       out  1      barrier open
//   RED_LED         out  1      stop / error indication (blinks on error)
//   occupancy       out  CNT_W  cars currently inside
//   full            out  1      occupancy has reached CAPACITY
//   lockout         out  1      keypad locked out after too many failures
//   state_o         out  3      current controller state, for coverage

module parking_gate_ctrl #(
  parameter int unsigned     PW_W        = 4,
  parameter logic [PW_W-1:0] PASS1       = 4'h1,
  parameter logic [PW_W-1:0] PASS2       = 4'h2,
  parameter int unsigned     CAPACITY    = 8,
  parameter int unsigned     TIMEOUT     = 32,
  parameter int unsigned     MAX_TRIES   = 3,
  parameter int unsigned     LOCK_CYCLES = 64,
  parameter int unsigned     BLINK_LOG2  = 2,
  localparam int unsigned    CNT_W       = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sensor_entrance,
  input  logic             sensor_exit,
  input  logic [PW_W-1:0]  password_1,
  input  logic [PW_W-1:0]  password_2,
  input  logic             pass_valid,
  input  logic             car_departed,
  output logic             GREEN_LED,
  output logic             RED_LED,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             lockout,
  output logic [2:0]       state_o
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam int unsigned LCK_W = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

  // Encodings are visible on state_o, so they are fixed explicitly.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_WRONG = 3'd2,
    S_RIGHT = 3'd3,
    S_STOP  = 3'd4,
    S_LOCK  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [LCK_W-1:0] lockCnt_q, lockCnt_d;
  logic [BLINK_LOG2:0] blink_q;

  logic             match;
  logic             fullNow;
  logic             timedOut;
  logic             lockDone;
  logic             lockHit;
  logic             carIn;
  logic [TRY_W-1:0] triesInc;

  assign match    = pass_valid && (password_1 == PASS1) && (password_2 == PASS2);
  assign fullNow  = (occ_q == CNT_W'(CAPACITY));
  assign timedOut = (timer_q == TMR_W'(TIMEOUT - 1));
  assign lockDone = (lockCnt_q == LCK_W'(LOCK_CYCLES - 1));
  assign triesInc = tries_q + TRY_W'(1);
  // This mismatch is the one that uses up the last allowed attempt.
  assign lockHit  = (triesInc >= TRY_W'(MAX_TRIES));

  // State, attempt counter and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      occ_q     <= '0;
      tries_q   <= '0;
      timer_q   <= '0;
      lockCnt_q <= '0;
      blink_q   <= '0;
    end else begin
      state_q   <= state_d;
      occ_q     <= occ_d;
      tries_q   <= tries_d;
      timer_q   <= timer_d;
      lockCnt_q <= lockCnt_d;
      blink_q   <= blink_q + 1'b1;
    end
  end

  // Next-state logic. A match is tested before the timeout, so a correct
  // password on the last allowed cycle still opens the barrier.
  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    carIn   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sensor_entrance && !fullNow) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (match) begin
          state_d = S_RIGHT;
        end else if (pass_valid) begin
          state_d = S_WRONG;
          tries_d = triesInc;
        end else if (timedOut) begin
          state_d = S_IDLE;
        end
      end
      S_WRONG: begin
        if (match) begin
          state_d = S_RIGHT;
        end else if (pass_valid) begin
          tries_d = triesInc;
          if (lockHit) state_d = S_LOCK;
        end else if (timedOut) begin
          state_d = S_IDLE;
        end
      end
      S_RIGHT: begin
        // The car passing the barrier is counted in, even when a tailgater
        // is already waiting behind it.
        if (sensor_exit) begin
          carIn   = 1'b1;
          state_d = sensor_entrance ? S_STOP : S_IDLE;
        end
      end
      S_STOP: begin
        if (fullNow) begin
          state_d = S_IDLE;
        end else if (match) begin
          state_d = S_RIGHT;
        end else if (pass_valid) begin
          tries_d = triesInc;
          if (lockHit) state_d = S_LOCK;
        end
      end
      S_LOCK: begin
        if (lockDone) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Leaving lockout always lands in IDLE, so this also covers that exit.
    if (state_d == S_IDLE || state_d == S_RIGHT) tries_d = '0;
  end

  // Inactivity timer for the keypad states. It restarts on any state change
  // or keypad strobe. Lockout has its own counter because pass_valid must
  // not stretch it.
  always_comb begin
    timer_d = '0;
    if (state_d == state_q && !pass_valid &&
        (state_q == S_WAIT || state_q == S_WRONG)) begin
      timer_d = timer_q + TMR_W'(1);
    end
    lockCnt_d = '0;
    if (state_q == S_LOCK && state_d == S_LOCK) lockCnt_d = lockCnt_q + LCK_W'(1);
  end

  // Occupancy saturates at both ends. An arrival and a departure in the
  // same cycle cancel out.
  always_comb begin
    occ_d = occ_q;
    if (carIn && !car_departed) begin
      if (!fullNow) occ_d = occ_q + CNT_W'(1);
    end else if (!carIn && car_departed) begin
      if (occ_q != '0) occ_d = occ_q - CNT_W'(1);
    end
  end

  // Moore outputs, decoded from the registered state.
  always_comb begin
    GREEN_LED = 1'b0;
    RED_LED   = 1'b0;
    lockout   = 1'b0;
    case (state_q)
      S_IDLE:         RED_LED = fullNow;
      S_WAIT, S_STOP: RED_LED = 1'b1;
      S_WRONG:        RED_LED = blink_q[BLINK_LOG2];
      S_RIGHT:        GREEN_LED = 1'b1;
      S_LOCK: begin
        RED_LED = blink_q[BLINK_LOG2];
        lockout = 1'b1;
      end
      default: ;
    endcase
  end

  assign occupancy = occ_q;
  assign full      = fullNow;
  assign state_o   = state_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Testbench for parking_gate_ctrl: table-driven vectors, directed multi-cycle
// sequences, and a randomised run checked against a behavioural model.
module tb_parking_gate_ctrl;

  localparam int         PW_W        = 4;
  localparam logic [3:0] PASS1       = 4'h1;
  localparam logic [3:0] PASS2       = 4'h2;
  localparam int         CAPACITY    = 8;
  localparam int         TIMEOUT     = 32;
  localparam int         MAX_TRIES   = 3;
  localparam int         LOCK_CYCLES = 64;
  localparam int         BLINK_LOG2  = 2;

  localparam int ST_IDLE = 0, ST_WAIT = 1, ST_WRONG = 2, ST_RIGHT = 3, ST_STOP = 4, ST_LOCK = 5;

  logic       clk, reset_n;
  logic       sensor_entrance, sensor_exit, pass_valid, car_departed;
  logic [3:0] password_1, password_2;
  logic       GREEN_LED, RED_LED, full, lockout;
  logic [3:0] occupancy;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  parking_gate_ctrl #(
    .PW_W(PW_W), .PASS1(PASS1), .PASS2(PASS2), .CAPACITY(CAPACITY),
    .TIMEOUT(TIMEOUT), .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES),
    .BLINK_LOG2(BLINK_LOG2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .sensor_entrance(sensor_entrance), .sensor_exit(sensor_exit),
    .password_1(password_1), .password_2(password_2),
    .pass_valid(pass_valid), .car_departed(car_departed),
    .GREEN_LED(GREEN_LED), .RED_LED(RED_LED), .occupancy(occupancy),
    .full(full), .lockout(lockout), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: the current mode, the number of cars inside, the
  // wrong attempts so far, the cycles since the last keypad activity, the
  // lockout cycles still to serve, and the blink phase.
  typedef struct {
    int st;
    int occ;
    int tries;
    int idle;
    int lockLeft;
    int cyc;
  } model_t;

  model_t m = '{default: 0};

  function automatic model_t modelNext(model_t cur, logic ent, logic ext, logic pv,
                                       logic dep, logic [3:0] a, logic [3:0] b);
    model_t nx;
    logic   ok;
    logic   isFull;
    int     carIn;
    nx     = cur;
    ok     = pv && (a == PASS1) && (b == PASS2);
    isFull = (cur.occ == CAPACITY);
    carIn  = 0;
    nx.cyc = (cur.cyc + 1) % (1 << (BLINK_LOG2 + 1));
    case (cur.st)
      ST_IDLE: if (ent && !isFull) nx.st = ST_WAIT;
      ST_WAIT: begin
        if (ok) nx.st = ST_RIGHT;
        else if (pv) begin nx.st = ST_WRONG; nx.tries = cur.tries + 1; end
        else if (cur.idle + 1 >= TIMEOUT) nx.st = ST_IDLE;
      end
      ST_WRONG: begin
        if (ok) nx.st = ST_RIGHT;
        else if (pv) begin
          nx.tries = cur.tries + 1;
          if (nx.tries >= MAX_TRIES) nx.st = ST_LOCK;
        end else if (cur.idle + 1 >= TIMEOUT) nx.st = ST_IDLE;
      end
      ST_RIGHT: begin
        if (ext) begin carIn = 1; nx.st = ent ? ST_STOP : ST_IDLE; end
      end
      ST_STOP: begin
        if (isFull) nx.st = ST_IDLE;
        else if (ok) nx.st = ST_RIGHT;
        else if (pv) begin
          nx.tries = cur.tries + 1;
          if (nx.tries >= MAX_TRIES) nx.st = ST_LOCK;
        end
      end
      ST_LOCK: begin
        nx.lockLeft = cur.lockLeft - 1;
        if (nx.lockLeft == 0) nx.st = ST_IDLE;
      end
      default: nx.st = ST_IDLE;
    endcase
    if (nx.st == ST_LOCK && cur.st != ST_LOCK) nx.lockLeft = LOCK_CYCLES;
    if (nx.st == ST_IDLE || nx.st == ST_RIGHT) nx.tries = 0;
    nx.idle = (nx.st != cur.st || pv) ? 0 : cur.idle + 1;
    if (carIn == 1 && !dep) nx.occ = (cur.occ < CAPACITY) ? cur.occ + 1 : cur.occ;
    else if (carIn == 0 && dep) nx.occ = (cur.occ > 0) ? cur.occ - 1 : 0;
    return nx;
  endfunction

  function automatic int modelRed(model_t s);
    int blink;
    blink = (s.cyc >> BLINK_LOG2) & 1;
    case (s.st)
      ST_IDLE:          return (s.occ == CAPACITY) ? 1 : 0;
      ST_WAIT, ST_STOP: return 1;
      ST_WRONG, ST_LOCK: return blink;
      default:          return 0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= '{default: 0};
    else m <= modelNext(m, sensor_entrance, sensor_exit, pass_valid, car_departed,
                        password_1, password_2);
  end

  typedef struct {
    logic       ent, ext, pv, dep;
    logic [3:0] a, b;
    int         expState, expOcc;
    logic       chkLeds, expGreen, expRed;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mkVec(logic ent, logic ext, logic [3:0] a, logic [3:0] b,
                                 logic pv, logic dep, int st, int occ,
                                 logic chk, logic g, logic r);
    vec_t v;
    v.ent = ent; v.ext = ext; v.a = a; v.b = b; v.pv = pv; v.dep = dep;
    v.expState = st; v.expOcc = occ; v.chkLeds = chk; v.expGreen = g; v.expRed = r;
    return v;
  endfunction

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name);
    checkVal({name, ".state"},   int'(state_o),   m.st);
    checkVal({name, ".occ"},     int'(occupancy), m.occ);
    checkVal({name, ".full"},    int'(full),      (m.occ == CAPACITY) ? 1 : 0);
    checkVal({name, ".green"},   int'(GREEN_LED), (m.st == ST_RIGHT) ? 1 : 0);
    checkVal({name, ".red"},     int'(RED_LED),   modelRed(m));
    checkVal({name, ".lockout"}, int'(lockout),   (m.st == ST_LOCK) ? 1 : 0);
  endtask

  task automatic checkAllZero(input string name);
    checkVal({name, ".state"},   int'(state_o),   0);
    checkVal({name, ".occ"},     int'(occupancy), 0);
    checkVal({name, ".full"},    int'(full),      0);
    checkVal({name, ".green"},   int'(GREEN_LED), 0);
    checkVal({name, ".red"},     int'(RED_LED),   0);
    checkVal({name, ".lockout"}, int'(lockout),   0);
  endtask

  // Drive one cycle of inputs, clock it in, and settle just past the edge.
  task automatic applyStimulus(input logic ent, input logic ext, input logic [3:0] a,
                               input logic [3:0] b, input logic pv, input logic dep);
    sensor_entrance = ent; sensor_exit = ext;
    password_1 = a; password_2 = b;
    pass_valid = pv; car_departed = dep;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string name, input logic ent, input logic ext, input logic [3:0] a,
                      input logic [3:0] b, input logic pv, input logic dep);
    applyStimulus(ent, ext, a, b, pv, dep);
    checkOutput(name);
  endtask

  task automatic admitCar();
    step("admit.wait", 1, 0, 0, 0, 0, 0);
    step("admit.pass", 1, 0, PASS1, PASS2, 1, 0);
    step("admit.exit", 0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog expired got=0 want=1");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int n;
    //                ent ext a   b   pv dep st        occ chk g  r
    vecs[0]  = mkVec(1, 0, 0, 0, 0, 0, ST_WAIT,  0, 1, 0, 1);
    vecs[1]  = mkVec(1, 0, 1, 2, 1, 0, ST_RIGHT, 0, 1, 1, 0);
    vecs[2]  = mkVec(0, 1, 0, 0, 0, 0, ST_IDLE,  1, 1, 0, 0);
    vecs[3]  = mkVec(1, 0, 0, 0, 0, 0, ST_WAIT,  1, 1, 0, 1);
    vecs[4]  = mkVec(1, 0, 1, 2, 1, 0, ST_RIGHT, 1, 1, 1, 0);
    vecs[5]  = mkVec(1, 1, 0, 0, 0, 0, ST_STOP,  2, 1, 0, 1);
    vecs[6]  = mkVec(0, 0, 1, 2, 1, 0, ST_RIGHT, 2, 1, 1, 0);
    vecs[7]  = mkVec(0, 1, 0, 0, 0, 1, ST_IDLE,  2, 1, 0, 0);
    vecs[8]  = mkVec(0, 0, 0, 0, 0, 1, ST_IDLE,  1, 1, 0, 0);
    vecs[9]  = mkVec(0, 0, 0, 0, 0, 1, ST_IDLE,  0, 1, 0, 0);
    vecs[10] = mkVec(0, 0, 0, 0, 0, 1, ST_IDLE,  0, 1, 0, 0);
    vecs[11] = mkVec(1, 0, 0, 0, 0, 0, ST_WAIT,  0, 1, 0, 1);
    vecs[12] = mkVec(1, 0, 1, 3, 1, 0, ST_WRONG, 0, 0, 0, 0);
    vecs[13] = mkVec(0, 0, 1, 2, 1, 0, ST_RIGHT, 0, 1, 1, 0);
    vecs[14] = mkVec(0, 1, 0, 0, 0, 0, ST_IDLE,  1, 1, 0, 0);

    reset_n = 1'b0;
    sensor_entrance = 0; sensor_exit = 0; pass_valid = 0; car_departed = 0;
    password_1 = 0; password_2 = 0;
    #3;
    checkAllZero("reset");
    #19 reset_n = 1'b1;

    $display("[TB] table vectors");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ent, vecs[i].ext, vecs[i].a, vecs[i].b, vecs[i].pv, vecs[i].dep);
      checkVal($sformatf("vec%0d.state", i), int'(state_o), vecs[i].expState);
      checkVal($sformatf("vec%0d.occ", i), int'(occupancy), vecs[i].expOcc);
      if (vecs[i].chkLeds) begin
        checkVal($sformatf("vec%0d.green", i), int'(GREEN_LED), int'(vecs[i].expGreen));
        checkVal($sformatf("vec%0d.red", i), int'(RED_LED), int'(vecs[i].expRed));
      end
    end

    $display("[TB] async reset in RIGHT_PASS");
    admitCar();
    admitCar();
    step("rst.wait", 1, 0, 0, 0, 0, 0);
    step("rst.pass", 1, 0, PASS1, PASS2, 1, 0);
    checkVal("rst.preState", int'(state_o), ST_RIGHT);
    checkVal("rst.preOcc", int'(occupancy), 3);
    #2 reset_n = 1'b0;
    #1 checkAllZero("rstAsync");
    @(posedge clk);
    #3 reset_n = 1'b1;
    step("rst.after", 0, 0, 0, 0, 0, 0);

    $display("[TB] lockout");
    step("lock.wait", 1, 0, 0, 0, 0, 0);
    step("lock.bad1", 0, 0, 5, 5, 1, 0);
    checkVal("lock.wrong", int'(state_o), ST_WRONG);
    step("lock.bad2", 0, 0, 5, 5, 1, 0);
    step("lock.bad3", 0, 0, 5, 5, 1, 0);
    checkVal("lock.entered", int'(lockout), 1);
    n = 1;
    for (int i = 0; i < 200 && lockout; i++) begin
      step("lock.hold", 1, 1, PASS1, PASS2, 1, 0);
      if (lockout) n++;
    end
    checkVal("lock.length", n, LOCK_CYCLES);
    checkVal("lock.exitIdle", int'(state_o), ST_IDLE);
    step("lock.retry", 1, 0, 0, 0, 0, 0);
    step("lock.good", 0, 0, PASS1, PASS2, 1, 0);
    checkVal("lock.accepted", int'(state_o), ST_RIGHT);
    step("lock.exit", 0, 1, 0, 0, 0, 0);

    $display("[TB] capacity");
    for (int i = 0; i < 20 && m.occ < CAPACITY; i++) admitCar();
    checkVal("cap.full", int'(full), 1);
    checkVal("cap.red", int'(RED_LED), 1);
    step("cap.blocked", 1, 0, 0, 0, 0, 0);
    checkVal("cap.stayIdle", int'(state_o), ST_IDLE);
    step("cap.depart", 0, 0, 0, 0, 0, 1);
    checkVal("cap.occ7", int'(occupancy), CAPACITY - 1);
    checkVal("cap.notFull", int'(full), 0);

    $display("[TB] tailgater");
    step("tg.wait", 1, 0, 0, 0, 0, 0);
    step("tg.pass", 1, 0, PASS1, PASS2, 1, 0);
    step("tg.stopFull", 1, 1, 0, 0, 0, 0);
    checkVal("tg.stopState", int'(state_o), ST_STOP);
    checkVal("tg.stopOcc", int'(occupancy), CAPACITY);
    step("tg.fullIdle", 0, 0, 0, 0, 0, 0);
    checkVal("tg.fullToIdle", int'(state_o), ST_IDLE);
    step("tg.dep1", 0, 0, 0, 0, 0, 1);
    step("tg.dep2", 0, 0, 0, 0, 0, 1);
    step("tg.wait2", 1, 0, 0, 0, 0, 0);
    step("tg.pass2", 1, 0, PASS1, PASS2, 1, 0);
    step("tg.stop2", 1, 1, 0, 0, 0, 0);
    checkVal("tg.stop2State", int'(state_o), ST_STOP);
    step("tg.repass", 0, 0, PASS1, PASS2, 1, 0);
    checkVal("tg.repassState", int'(state_o), ST_RIGHT);
    step("tg.exit", 0, 1, 0, 0, 0, 0);

    $display("[TB] timeout");
    step("to.dep", 0, 0, 0, 0, 0, 1);
    step("to.wait", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) step("to.idle", 0, 0, 0, 0, 0, 0);
    checkVal("to.stillWait", int'(state_o), ST_WAIT);
    step("to.expire", 0, 0, 0, 0, 0, 0);
    checkVal("to.expired", int'(state_o), ST_IDLE);
    step("to.wait2", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < TIMEOUT - 2; i++) step("to.idle2", 0, 0, 0, 0, 0, 0);
    step("to.strobe1", 0, 0, 7, 7, 1, 0);
    checkVal("to.wrong", int'(state_o), ST_WRONG);
    for (int i = 0; i < TIMEOUT - 2; i++) step("to.idle3", 0, 0, 0, 0, 0, 0);
    step("to.strobe2", 0, 0, 7, 7, 1, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) step("to.idle4", 0, 0, 0, 0, 0, 0);
    checkVal("to.restarted", int'(state_o), ST_WRONG);
    step("to.expire2", 0, 0, 0, 0, 0, 0);
    checkVal("to.expired2", int'(state_o), ST_IDLE);

    $display("[TB] randomised run");
    for (int i = 0; i < 600; i++) begin
      logic       ent, ext, pv, dep;
      logic [3:0] a, b;
      ent = ($urandom_range(0, 3) != 0);
      ext = ($urandom_range(0, 2) == 0);
      pv  = ($urandom_range(0, 3) == 0);
      dep = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) begin a = PASS1; b = PASS2; end
      else begin a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); end
      step("rand", ent, ext, a, b, pv, dep);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
